// File: rtl/hgcal_link_pkg.sv
// Shared definitions for the HGCAL autoencoder link (framer and deframer sides).
// Holds the link defaults, the frame state encoding and the payload word-count helper.
package hgcal_link_pkg;

  localparam int          LINK_W_DEF    = 8;
  localparam int          CODE_W_DEF    = 2;
  localparam logic [7:0]  SYNC_WORD_DEF = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } link_state_e;

  // Number of link words needed to carry one full latent vector.
  function automatic int calc_words(input int latent_n, input int code_w, input int link_w);
    return (latent_n * code_w) / link_w;
  endfunction

endpackage

// File: rtl/hgcal_latent_slice_reg.sv
// Shadow latent vector for the deframer: one link-word slice is written per payload beat.
// Contents persist across frames; only the FSM decides when they are published.
module hgcal_latent_slice_reg
  import hgcal_link_pkg::*;
#(
  parameter int LINK_W = LINK_W_DEF,
  parameter int WORDS  = 4,
  parameter int IDX_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [LINK_W-1:0]         wr_data_i,
  output logic [WORDS*LINK_W-1:0]   vec_o
);

  logic [WORDS*LINK_W-1:0] vec_q;

  // Indexed slice write of the shadow vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q <= '0;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(w))) begin
          vec_q[w*LINK_W +: LINK_W] <= wr_data_i;
        end
      end
    end
  end

  assign vec_o = vec_q;

endmodule

// File: rtl/hgcal_latent_deframer.sv
// Receive side of the HGCAL latent link: hunts for sync, collects payload words,
// verifies the XOR checksum and hands one verified latent vector to the decoder.
module hgcal_latent_deframer
  import hgcal_link_pkg::*;
#(
  parameter int                LATENT_N  = 16,
  parameter int                CODE_W    = CODE_W_DEF,
  parameter int                LINK_W    = LINK_W_DEF,
  parameter logic [LINK_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LINK_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LATENT_N*CODE_W-1:0]   out_latent,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_err,
  output logic [ERR_CNT_W-1:0]         err_cnt,
  output logic                         in_sync
);

  localparam int WORDS = calc_words(LATENT_N, CODE_W, LINK_W);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int VEC_W = LATENT_N * CODE_W;

  link_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LINK_W-1:0]       xor_q, xor_d;
  logic [VEC_W-1:0]        latent_q, latent_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [ERR_CNT_W-1:0]    cnt_q, cnt_d;
  logic                    accept_s;
  logic                    wr_en_s;
  logic [VEC_W-1:0]        shadow_s;

  hgcal_latent_slice_reg #(
    .LINK_W (LINK_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_data),
    .vec_o     (shadow_s)
  );

  assign in_ready = (state_q != HOLD);
  assign accept_s = in_valid && in_ready;

  // Frame FSM next-state and datapath updates; frame_err defaults low so it pulses.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    latent_d = latent_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept_s && (in_data == SYNC_WORD)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          xor_d   = '0;
        end else begin
          state_d = HUNT;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          xor_d   = xor_q ^ in_data;
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_d = CHECK;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      CHECK: begin
        if (accept_s) begin
          if (in_data == xor_q) begin
            latent_d = shadow_s;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            if (cnt_q != {ERR_CNT_W{1'b1}}) begin
              cnt_d = cnt_q + ERR_CNT_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end
        end else begin
          state_d = CHECK;
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = HUNT;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
        xor_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      xor_q    <= '0;
      latent_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      latent_q <= latent_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_latent = latent_q;
  assign out_valid  = valid_q;
  assign frame_err  = err_q;
  assign err_cnt    = cnt_q;
  assign in_sync    = (state_q == PAYLOAD) || (state_q == CHECK);

endmodule

// File: tb/tb_hgcal_latent_deframer.sv
// Directed self-checking bench for hgcal_latent_deframer with hand-computed frames.
module tb_hgcal_latent_deframer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_latent;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        in_sync;

  int checks;
  int errors;
  int valid_seen;
  int err_seen;

  hgcal_latent_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_latent (out_latent),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .in_sync    (in_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) valid_seen++;
    if (frame_err) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] payload, input logic [7:0] chk);
    drive(8'hA5);
    for (int w = 0; w < 4; w++) drive(payload[w*8 +: 8]);
    drive(chk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || out_latent !== 32'h0 || frame_err !== 1'b0 ||
        err_cnt !== 8'h0 || in_sync !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b latent=%h err=%b cnt=%0d sync=%b rdy=%b (want 0 0 0 0 0 1)",
               out_valid, out_latent, frame_err, err_cnt, in_sync, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame;
    int v0, e0;
    v0 = valid_seen;
    e0 = err_seen;
    send_frame(32'hFF00E41B, 8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_latent !== 32'hFF00E41B) begin
      errors++;
      $display("FAIL good_out: valid=%b latent=%h want 1 ff00e41b", out_valid, out_latent);
    end
    checks++;
    if (out_latent[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL good_code0: got %b want 11", out_latent[1:0]);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL good_hold_ready: got %b want 0", in_ready);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL good_release: valid=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL good_pulses: valid_cycles=%0d err_cycles=%0d cnt=%0d want 1 0 0",
               valid_seen - v0, err_seen - e0, err_cnt);
    end
  endtask

  task automatic test_bad_checksum;
    int v0, e0;
    v0 = valid_seen;
    e0 = err_seen;
    send_frame(32'hFF00E41B, 8'h01);
    checks++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 8'd1 || in_sync !== 1'b0) begin
      errors++;
      $display("FAIL bad_flag: err=%b valid=%b cnt=%0d sync=%b want 1 0 1 0",
               frame_err, out_valid, err_cnt, in_sync);
    end
    idle(1);
    checks++;
    if (frame_err !== 1'b0 || err_seen - e0 !== 1 || valid_seen - v0 !== 0) begin
      errors++;
      $display("FAIL bad_pulse: err=%b err_cycles=%0d valid_cycles=%0d want 0 1 0",
               frame_err, err_seen - e0, valid_seen - v0);
    end
    checks++;
    if (out_latent !== 32'hFF00E41B) begin
      errors++;
      $display("FAIL bad_latent_kept: got %h want ff00e41b", out_latent);
    end
    send_frame(32'h44332211, 8'h44);
    checks++;
    if (out_valid !== 1'b1 || out_latent !== 32'h44332211) begin
      errors++;
      $display("FAIL bad_recover: valid=%b latent=%h want 1 44332211", out_valid, out_latent);
    end
    idle(1);
  endtask

  task automatic test_hunt;
    logic [7:0] garbage [3];
    garbage[0] = 8'h00;
    garbage[1] = 8'hA4;
    garbage[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      drive(garbage[i]);
      checks++;
      if (in_sync !== 1'b0) begin
        errors++;
        $display("FAIL hunt_garbage%0d: sync=%b want 0", i, in_sync);
      end
    end
    drive(8'hA5);
    checks++;
    if (in_sync !== 1'b1) begin
      errors++;
      $display("FAIL hunt_sync: got %b want 1", in_sync);
    end
    drive(8'h1B); drive(8'hE4); drive(8'h00); drive(8'hFF); drive(8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_latent !== 32'hFF00E41B || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL hunt_frame: valid=%b latent=%h cnt=%0d want 1 ff00e41b 1",
               out_valid, out_latent, err_cnt);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_frame(32'hFF00E41B, 8'h00);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_latent !== 32'hFF00E41B) begin
        errors++;
        $display("FAIL bp_hold%0d: rdy=%b valid=%b latent=%h want 0 1 ff00e41b",
                 i, in_ready, out_valid, out_latent);
      end
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || in_sync !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b sync=%b rdy=%b want 0 0 1", out_valid, in_sync, in_ready);
    end
    send_frame(32'h44332211, 8'h44);
    checks++;
    if (out_valid !== 1'b1 || out_latent !== 32'h44332211) begin
      errors++;
      $display("FAIL bp_next: valid=%b latent=%h want 1 44332211", out_valid, out_latent);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_frame;
    drive(8'hA5); drive(8'h1B); drive(8'hE4);
    checks++;
    if (in_sync !== 1'b1) begin
      errors++;
      $display("FAIL mid_sync: got %b want 1", in_sync);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_latent !== 32'h0 || frame_err !== 1'b0 ||
        err_cnt !== 8'h0 || in_sync !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: valid=%b latent=%h err=%b cnt=%0d sync=%b rdy=%b want 0 0 0 0 0 1",
               out_valid, out_latent, frame_err, err_cnt, in_sync, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    send_frame(32'hFF00E41B, 8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_latent !== 32'hFF00E41B) begin
      errors++;
      $display("FAIL mid_recover: valid=%b latent=%h want 1 ff00e41b", out_valid, out_latent);
    end
    idle(1);
  endtask

  task automatic test_saturation;
    logic [7:0] exp_cnt;
    exp_cnt = 8'd0;
    for (int i = 0; i < 260; i++) begin
      send_frame(32'hFF00E41B, 8'h01);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (frame_err !== 1'b1 || err_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL sat_frame%0d: err=%b cnt=%0d want 1 %0d", i, frame_err, err_cnt, exp_cnt);
      end
    end
    idle(3);
    checks++;
    if (err_cnt !== 8'd255 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_final: cnt=%0d err=%b want 255 0", err_cnt, frame_err);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    valid_seen = 0;
    err_seen   = 0;
    rst       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_hunt;
    test_backpressure;
    test_reset_mid_frame;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hgcal_latent_deframer.md
Name: hgcal_latent_deframer

Overview:
- Decoder-side receiver for the HGCAL autoencoder link.
- The encoder side packs the quantized 2-bit latent codes produced by its neuron LUT layers into byte words and frames them. This block is the other end of that link.
- Functions: hunts for frame sync, accepts payload words with valid/ready, verifies an XOR checksum, then presents one full latent vector to the first decoder LUT layer.
- Code i occupies vector bits [2i+1:2i], the same packing the neuron layers use on their inputs.

Parameters:
- LATENT_N, 16, number of latent codes per frame.
- CODE_W, 2, bits per latent code.
- LINK_W, 8, link word width. Must be a multiple of CODE_W; LATENT_N*CODE_W must be a multiple of LINK_W.
- SYNC_WORD, 8'hA5, frame header value.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_data  in  LINK_W  link word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- out_latent  out  LATENT_N*CODE_W  assembled latent vector.
- out_valid  out  1  out_latent valid.
- out_ready  in  1  downstream accepts.
- frame_err  out  1  one-cycle pulse on checksum failure.
- err_cnt  out  ERR_CNT_W  saturating count of checksum failures.
- in_sync  out  1  high in PAYLOAD or CHECK.

Behaviour:
- Derived constant WORDS = LATENT_N*CODE_W/LINK_W (default 4). A frame is: SYNC_WORD, then WORDS payload words, then one checksum word equal to the XOR of the payload words.
- Transfers:
  - A word is accepted when in_valid && in_ready.
  - The output is consumed when out_valid && out_ready.
- Reset (rst low, asynchronous):
  - State = HUNT; word index = 0; running XOR = 0; out_latent = 0; out_valid = 0; frame_err = 0; err_cnt = 0; in_sync = 0.
  - A reset in the middle of a frame discards the partial frame. There is no resume.
- in_ready = 1 in HUNT, PAYLOAD and CHECK; 0 in HOLD.
- States and transitions:
  - HUNT:
    - Accepted word == SYNC_WORD → PAYLOAD, index = 0, XOR = 0.
    - Any other accepted word is discarded silently.
  - PAYLOAD:
    - Each accepted word is written into the shadow vector slice [LINK_W*(idx+1)-1 : LINK_W*idx], XORed into the running checksum, and the index is incremented.
    - On accepting word WORDS-1 → CHECK.
    - SYNC_WORD values inside the payload are treated as data; there is no resync.
  - CHECK, on the accepted word:
    - If it equals the running XOR: copy the shadow vector to out_latent, set out_valid = 1, → HOLD.
    - Otherwise: frame_err = 1 for exactly the next cycle, err_cnt += 1 (saturates at all-ones and never wraps), out_latent is unchanged, → HUNT.
  - HOLD:
    - out_valid held at 1 and out_latent held stable until out_ready.
    - On out_valid && out_ready: out_valid = 0 on the next edge, → HUNT.
- Latency: out_valid rises on the clock edge that accepts the checksum word; it is visible in the following cycle.
- Minimum frame period is WORDS+2 cycles plus one HOLD cycle. Throughput is therefore one frame per WORDS+3 cycles when out_ready is held high.
- in_valid gaps are allowed in any state; the FSM only advances on an accepted word.
- out_ready while out_valid = 0 has no effect.
- in_data is ignored whenever in_ready = 0.
- The shadow vector is not cleared between frames. Only verified frames are ever copied to out_latent.

Decomposition:
- Shared package hgcal_link_pkg:
  - SYNC_WORD, LINK_W and CODE_W defaults.
  - State enum {HUNT, PAYLOAD, CHECK, HOLD}.
  - A function computing WORDS.
  - The same package is used by the encoder-side framer.
- Sub-module: hgcal_latent_slice_reg, the shadow vector with indexed slice write enable. It is natural to factor out; everything else stays in the top-level FSM.

Test Plan:
- Good frame: feed A5,1B,E4,00,FF,00 with in_valid continuous and out_ready = 1 → out_valid for 1 cycle; out_latent = 32'hFF00E41B; code0 = 2'b11; frame_err never set; err_cnt = 0.
- Bad checksum: A5,1B,E4,00,FF,01 → no out_valid; frame_err high for exactly 1 cycle; err_cnt = 1; the following good frame is still delivered correctly.
- Hunt with garbage: 00,A4,5A,A5 then a valid frame → leading garbage discarded; in_sync rises the cycle after A5 is accepted; output = 32'hFF00E41B.
- Backpressure: out_ready = 0 for 10 cycles after a good frame → in_ready = 0 and out_latent stable throughout; in_valid words offered meanwhile are not consumed; after out_ready = 1 the next frame (payload 11,22,33,44, checksum 44) gives out_latent = 32'h44332211.
- Reset mid-frame: drop rst after A5,1B,E4 → all outputs go to reset values immediately (asynchronously); after rst is released, a full good frame is received correctly.
- Saturation: 260 bad frames with ERR_CNT_W = 8 → err_cnt = 255, stable; frame_err still pulses on each failure.
